// File: rtl/sram_1p_req_arbiter.sv
// sram_1p_req_arbiter
//   Front-end controller for a single-port array macro with 1-cycle read
//   latency. After reset it optionally zero-fills the whole array, then
//   arbitrates independent write and read request channels onto the single
//   RW0 port. When both channels request together, priority alternates. Read
//   data comes back on a valid-qualified response channel. A holding
//   register keeps the last word stable between responses.
//
// Ports
//   clock, reset        clock (also drives the macro), sync active-high reset
//   w_valid/w_ready     write request handshake; w_addr, w_data payload
//   r_valid/r_ready     read request handshake; r_addr payload
//   resp_valid          one-cycle pulse, read data on resp_data
//   resp_data           read data, holds the last returned word otherwise
//   init_done           high once the zero-fill has completed
//   RW0_addr/en/wmode/wdata   macro drive (wmode 1 = write)
//   RW0_rdata           macro read data, valid the cycle after a read
module sram_1p_req_arbiter #(
  parameter int unsigned ADDR_W        = 8,
  parameter int unsigned DATA_W        = 72,
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              init_done,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [DATA_W-1:0] RW0_wdata,
  input  logic [DATA_W-1:0] RW0_rdata
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_init_addr;
  logic                r_rd_pri;
  logic                r_rd_fire_q;
  logic                r_init_done;
  logic [DATA_W-1:0]   r_hold_q;

  logic                w_run;
  logic                w_wr_fire;
  logic                w_rd_fire;

  assign w_run = (r_state == ST_RUN);

  // Each ready depends only on the other channel's valid and the priority
  // bit, so a lone requester is always granted and a conflict has one winner.
  assign w_ready   = w_run && !(r_valid && r_rd_pri);
  assign r_ready   = w_run && !(w_valid && !r_rd_pri);
  assign w_wr_fire = w_valid && w_ready;
  assign w_rd_fire = r_valid && r_ready;

  assign init_done  = r_init_done;
  assign resp_valid = r_rd_fire_q;
  // Macro output is only meaningful the cycle after a read; otherwise show
  // the held word.
  assign resp_data  = r_rd_fire_q ? RW0_rdata : r_hold_q;

  always_comb begin
    RW0_en    = 1'b0;
    RW0_wmode = 1'b0;
    RW0_addr  = '0;
    RW0_wdata = '0;
    if (!w_run) begin
      RW0_en    = 1'b1;
      RW0_wmode = 1'b1;
      RW0_addr  = r_init_addr;
    end else if (w_wr_fire) begin
      RW0_en    = 1'b1;
      RW0_wmode = 1'b1;
      RW0_addr  = w_addr;
      RW0_wdata = w_data;
    end else if (w_rd_fire) begin
      RW0_en    = 1'b1;
      RW0_addr  = r_addr;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= INIT_ON_RESET ? ST_INIT : ST_RUN;
      r_init_addr <= '0;
      r_rd_pri    <= 1'b0;
      r_rd_fire_q <= 1'b0;
      r_hold_q    <= '0;
      r_init_done <= !INIT_ON_RESET;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_init_addr <= r_init_addr + ADDR_W'(1);
          if (r_init_addr == '1) begin
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_valid && r_valid)
            r_rd_pri <= !r_rd_pri;
        end
        default: r_state <= ST_INIT;
      endcase
      r_rd_fire_q <= w_rd_fire;
      if (r_rd_fire_q)
        r_hold_q <= RW0_rdata;
    end
  end

endmodule

// File: tb/tb_sram_1p_req_arbiter.sv
// Testbench for sram_1p_req_arbiter: behavioural array macro, reference
// memory plus arbitration model, and a response scoreboard queue.
module tb_sram_1p_req_arbiter;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 72;
  localparam int unsigned DEPTH = 256;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          w_valid = 1'b0;
  logic          w_ready;
  logic [AW-1:0] w_addr = '0;
  logic [DW-1:0] w_data = '0;
  logic          r_valid = 1'b0;
  logic          r_ready;
  logic [AW-1:0] r_addr = '0;
  logic          resp_valid;
  logic [DW-1:0] resp_data;
  logic          init_done;
  logic [AW-1:0] RW0_addr;
  logic          RW0_en;
  logic          RW0_wmode;
  logic [DW-1:0] RW0_wdata;
  logic [DW-1:0] RW0_rdata;

  always #5 clock = ~clock;

  sram_1p_req_arbiter #(
    .ADDR_W        (AW),
    .DATA_W        (DW),
    .INIT_ON_RESET (1'b1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .r_valid    (r_valid),
    .r_ready    (r_ready),
    .r_addr     (r_addr),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .init_done  (init_done),
    .RW0_addr   (RW0_addr),
    .RW0_en     (RW0_en),
    .RW0_wmode  (RW0_wmode),
    .RW0_wdata  (RW0_wdata),
    .RW0_rdata  (RW0_rdata)
  );

  function automatic logic [DW-1:0] junk();
    logic [95:0] g;
    g = {$urandom(), $urandom(), $urandom()};
    return g[DW-1:0];
  endfunction

  // Array macro: 1-cycle read latency, garbage on rdata when not reading.
  logic [DW-1:0] mem [DEPTH];
  initial for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= junk();
  always @(posedge clock) begin
    if (RW0_en && RW0_wmode) mem[RW0_addr] <= RW0_wdata;
    if (RW0_en && !RW0_wmode) RW0_rdata <= mem[RW0_addr];
    else                      RW0_rdata <= junk();
  end

  // Reference model state (state after the most recent clock edge).
  int unsigned   n_checks = 0;
  int unsigned   n_fail   = 0;
  int unsigned   m_fill   = 0;
  bit            m_run    = 1'b0;
  bit            m_rd_pri = 1'b0;
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_hold = '0;
  logic [DW-1:0] mon_exp;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: called at a negedge, drives inputs, checks the
  // combinational outputs against the model, returns at the next negedge.
  task automatic tick(input logic rst, input logic wv, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic rv, input logic [AW-1:0] ra);
    logic wr_rdy, rd_rdy, wg, rg;
    logic [AW-1:0] fa;
    #1;
    reset = rst; w_valid = wv; w_addr = wa; w_data = wd; r_valid = rv; r_addr = ra;
    #1;
    if (rst) begin
      m_fill = 0; m_run = 1'b0; m_rd_pri = 1'b0;
    end else begin
      check_eq("init_done", DW'(init_done), DW'(m_run));
      if (!m_run) begin
        fa = m_fill[AW-1:0];
        check_eq("init_w_ready", DW'(w_ready), '0);
        check_eq("init_r_ready", DW'(r_ready), '0);
        check_eq("init_en", DW'(RW0_en), DW'(1'b1));
        check_eq("init_wmode", DW'(RW0_wmode), DW'(1'b1));
        check_eq("init_addr", DW'(RW0_addr), DW'(fa));
        check_eq("init_wdata", RW0_wdata, '0);
        ref_mem[fa] = '0;
        m_fill++;
        if (m_fill == DEPTH) m_run = 1'b1;
      end else begin
        wr_rdy = !(rv && m_rd_pri);
        rd_rdy = !(wv && !m_rd_pri);
        wg = wv && wr_rdy;
        rg = rv && rd_rdy;
        check_eq("w_ready", DW'(w_ready), DW'(wr_rdy));
        check_eq("r_ready", DW'(r_ready), DW'(rd_rdy));
        check_eq("rw0_en", DW'(RW0_en), DW'(wg || rg));
        check_eq("rw0_wmode", DW'(RW0_wmode), DW'(wg));
        check_eq("rw0_addr", DW'(RW0_addr), wg ? DW'(wa) : (rg ? DW'(ra) : '0));
        check_eq("rw0_wdata", RW0_wdata, wg ? wd : '0);
        if (wg) ref_mem[wa] = wd;
        if (rg) exp_q.push_back(ref_mem[ra]);
        if (wv && rv) m_rd_pri = !m_rd_pri;
      end
    end
    @(negedge clock);
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  // Response scoreboard: every read granted last cycle must show up now.
  always @(negedge clock) begin
    if (reset) begin
      check_eq("rst_resp_valid", DW'(resp_valid), '0);
      check_eq("rst_resp_data", resp_data, '0);
      exp_q.delete();
      exp_hold = '0;
    end else if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      check_eq("resp_valid", DW'(resp_valid), DW'(1'b1));
      check_eq("resp_data", resp_data, mon_exp);
      exp_hold = mon_exp;
    end else begin
      check_eq("resp_unexpected", DW'(resp_valid), '0);
      check_eq("resp_hold", resp_data, exp_hold);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clock);
    tick(1'b1, 1'b0, '0, '0, 1'b0, '0);
    tick(1'b1, 1'b0, '0, '0, 1'b0, '0);

    // Zero-fill, then init_done on cycle 257
    repeat (DEPTH) idle();
    idle();

    // Every address reads back zero
    for (int unsigned a = 0; a < DEPTH; a++) tick(1'b0, 1'b0, '0, '0, 1'b1, AW'(a));
    idle();

    // Write then read-after-write, then hold for 5 idle cycles
    tick(1'b0, 1'b1, 8'h3C, 72'hAB_DEADBEEF_CAFEF00D, 1'b0, '0);
    tick(1'b0, 1'b0, '0, '0, 1'b1, 8'h3C);
    repeat (6) idle();

    // Sustained conflict: W, R, W, R
    for (int unsigned i = 0; i < 4; i++)
      tick(1'b0, 1'b1, AW'(32 + i), DW'(100 + i), 1'b1, AW'(64 + i));
    repeat (2) idle();

    // Same-address conflicts, write wins then read wins
    tick(1'b0, 1'b1, 8'h10, 72'h1, 1'b0, '0);
    tick(1'b0, 1'b1, 8'h10, 72'h2, 1'b1, 8'h10);
    tick(1'b0, 1'b0, '0, '0, 1'b1, 8'h10);
    tick(1'b0, 1'b1, 8'h10, 72'h3, 1'b1, 8'h10);
    tick(1'b0, 1'b1, 8'h10, 72'h3, 1'b0, '0);
    tick(1'b0, 1'b0, '0, '0, 1'b1, 8'h10);
    idle();

    // Random mixed traffic on a small address window
    for (int unsigned i = 0; i < 200; i++)
      tick(1'b0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), junk(),
           1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)));
    idle();

    // Read accepted, then reset the following cycle
    tick(1'b0, 1'b0, '0, '0, 1'b1, 8'h3C);
    tick(1'b1, 1'b0, '0, '0, 1'b0, '0);

    // Reset at INIT cycle 100: fill restarts at 0, full 256-cycle fill
    repeat (100) idle();
    tick(1'b1, 1'b0, '0, '0, 1'b0, '0);
    repeat (DEPTH) idle();
    repeat (2) idle();
    tick(1'b0, 1'b0, '0, '0, 1'b1, 8'h3C);
    repeat (2) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_1p_req_arbiter.md
# sram_1p_req_arbiter

Front-end controller for the 256x72 single-port array macro (`RW0_*` port, 1-cycle read latency). It clears the array after reset and arbitrates independent write and read request channels onto the single `RW0` port with alternating priority on conflicts. It also returns read data on a valid-qualified response channel with a holding register, because the macro output is only meaningful in the cycle after a read. It sits directly upstream of the array macro and is its only driver.

## Interface
Parameters:
- `ADDR_W`, 8: array address width; depth is 2^ADDR_W.
- `DATA_W`, 72: array word width.
- `INIT_ON_RESET`, 1: 1 = zero-fill the whole array after reset; 0 = ready immediately after reset.

Ports:
- Single clock `clock`; reset `reset` is synchronous, active-high.
- `clock`  in  1  clock for the block and for the array macro (`RW0_clk` is tied to `clock`)
- `reset`  in  1  synchronous active-high reset
- `w_valid`  in  1  write request
- `w_ready`  out  1  write accepted when `w_valid && w_ready`
- `w_addr`  in  ADDR_W  write address
- `w_data`  in  DATA_W  write data
- `r_valid`  in  1  read request
- `r_ready`  out  1  read accepted when `r_valid && r_ready`
- `r_addr`  in  ADDR_W  read address
- `resp_valid`  out  1  one-cycle pulse: read data present on `resp_data`
- `resp_data`  out  DATA_W  read data; holds the last returned word between responses
- `init_done`  out  1  high once the zero-fill is complete
- `RW0_addr`  out  ADDR_W  to macro
- `RW0_en`  out  1  to macro
- `RW0_wmode`  out  1  to macro; 1 = write
- `RW0_wdata`  out  DATA_W  to macro
- `RW0_rdata`  in  DATA_W  from macro

## Operation
- State machine: INIT and RUN.
  - Reset enters INIT when `INIT_ON_RESET=1`, otherwise RUN.
- INIT behaviour:
  - The 8-bit counter `init_addr` starts at 0.
  - Each cycle drives `RW0_en=1`, `RW0_wmode=1`, `RW0_addr=init_addr`, `RW0_wdata=0`, then increments.
  - After writing address 2^ADDR_W-1, the FSM moves to RUN. The counter wrap is not stored.
  - `w_ready=r_ready=0` throughout INIT.
- `init_done` is registered and equals (state==RUN).
- Arbitration in RUN uses a priority bit `rd_pri`:
  - `rd_pri` resets to 0 and toggles only in cycles where `w_valid && r_valid`.
  - `w_ready = RUN && !(r_valid && rd_pri)`.
  - `r_ready = RUN && !(w_valid && !rd_pri)`.
  - At most one request is granted per cycle. With no conflict, the single requester is always granted.
  - Requesters must not make `valid` depend on `ready`.
- Macro drive:
  - Write grant: `RW0_en=1`, `RW0_wmode=1`, `RW0_addr=w_addr`, `RW0_wdata=w_data`.
  - Read grant: `RW0_en=1`, `RW0_wmode=0`, `RW0_addr=r_addr`, `RW0_wdata=0`.
  - Otherwise `RW0_en=0` and the other macro outputs are 0.
- Same-address conflict: the losing request is serviced on a later cycle.
  - A read that loses to a write at the same address returns the new data.
  - A write that loses to a read leaves the read returning the old data.
- Response path:
  - `rd_fire_q` is a register holding `r_valid && r_ready`.
  - `resp_valid = rd_fire_q`.
  - `resp_data = rd_fire_q ? RW0_rdata : hold_q`.
  - `hold_q` loads `RW0_rdata` when `rd_fire_q`.
  - `resp_data` never exposes macro garbage.
- There is no response backpressure. Consumers must accept `resp_valid` unconditionally.

## Timing
- Reset values:
  - Registers: state=INIT (or RUN), `init_addr=0`, `rd_pri=0`, `rd_fire_q=0`, `hold_q=0`, `init_done=0` (1 if `INIT_ON_RESET=0`).
  - Outputs during reset cycle+1: `resp_valid=0`, `resp_data=0`, `w_ready=r_ready=0` when in INIT.
- INIT lasts exactly 2^ADDR_W cycles (256): `init_done` rises on the cycle after the last fill write.
- Read latency: accepted at cycle N gives `resp_valid=1` and data at cycle N+1.
- Throughput: one access per cycle; back-to-back reads give back-to-back responses.
- Write latency: a write accepted at N is visible to a read accepted at N+1 or later.
- Reset mid-operation:
  - Aborts INIT (counter restarts at 0).
  - An in-flight read is dropped: `resp_valid=0` the cycle after reset.
  - `hold_q` clears to 0.
- `w_ready` and `r_ready` are combinational from `r_valid`/`w_valid` and registered state.

## Test plan
- Reset with `INIT_ON_RESET=1`, then read every address after `init_done`:
  - `init_done` is 0 for 256 cycles and 1 on cycle 257.
  - Every read returns 72'h0.
- Write 0xAB_DEADBEEF_CAFEF00D to addr 0x3C at cycle N; read 0x3C at N+1:
  - `resp_valid=1` at N+2 with that data.
  - `resp_data` holds the value for the following 5 idle cycles with `resp_valid=0`.
- Hold `w_valid` and `r_valid` high for 4 cycles, distinct addresses:
  - Grants alternate W, R, W, R.
  - `rd_pri` sequence is 0, 1, 0, 1.
- Same address 0x10 (old value 0x1, new 0x2) in a first conflict cycle:
  - The write wins.
  - The read is granted next cycle and returns 0x2.
- Assert reset at INIT cycle 100:
  - Fill restarts at addr 0.
  - `init_done` rises exactly 256 cycles after reset release.
- Read accepted at cycle N, reset at N+1:
  - `resp_valid=0` and `resp_data=0` after reset.
